// File: rtl/freqgen_pkg.sv
// Shared definitions for the frequency-sweep sequencer.
//   - default widths and timeout
//   - sweep FSM state encoding, plus a decode of which states count as "active"
package freqgen_pkg;

    localparam int MD_W_DEF        = 8;
    localparam int DWELL_W_DEF     = 32;
    localparam int TIMEOUT_CYC_DEF = 1000000;

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_PROG      = 3'd1,
        S_WAIT_BUSY = 3'd2,
        S_WAIT_LOCK = 3'd3,
        S_DWELL     = 3'd4,
        S_STEP      = 3'd5,
        S_DONE      = 3'd6,
        S_ERR       = 3'd7
    } sweep_state_t;

    function automatic logic state_is_active(input sweep_state_t s);
        return !(s == S_IDLE || s == S_DONE || s == S_ERR);
    endfunction

endpackage

// File: rtl/sweep_timer.sv
// Loadable down-counter with terminal-count flag.
// Ports:
//   clk, reset_n   clock, async active-low reset
//   i_load         load i_load_val (has priority over counting)
//   i_load_val     value to load
//   i_en           decrement by one while nonzero
//   o_tc           high while the count equals 1 (last counting cycle)
module sweep_timer #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         i_load,
    input  logic [W-1:0] i_load_val,
    input  logic         i_en,
    output logic         o_tc
);

    logic [W-1:0] r_cnt;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_cnt <= '0;
        end else if (i_load) begin
            r_cnt <= i_load_val;
        end else if (i_en && (r_cnt != '0)) begin
            r_cnt <= r_cnt - W'(1);
        end
    end

    assign o_tc = (r_cnt == W'(1));

endmodule

// File: rtl/freq_sweep_ctrl.sv
// Stepped multiplier sweep sequencer for the DCM_CLKGEN SPI programmer.
// Each point: issue GO with M/D, wait for BUSY to rise and fall, wait for
// LOCKED, hold for the dwell time, then step M toward m_end.
// Optional macro FREQ_SWEEP_LOOP_EN: restart from m_start after each pass
// instead of stopping in DONE.
// Ports:
//   clk, reset_n                     clock, async active-low reset
//   start / abort                    start pulse / level abort (abort wins)
//   m_start, m_end, m_step, d_val    sweep parameters, latched on start
//   dwell                            hold cycles per point (0 acts as 1)
//   busy, lckd                       dcmspi BUSY, DCM LOCKED
//   multiplier, divider, go          programming interface to dcmspi
//   active, done, err, cur_m         status
//   dbg_state                        current FSM state
//
// go/done are one-cycle pulses; multiplier/divider only change in PROG and
// are therefore stable from the go cycle until the next point.
module freq_sweep_ctrl
    import freqgen_pkg::*;
#(
    parameter int MD_W        = MD_W_DEF,
    parameter int DWELL_W     = DWELL_W_DEF,
    parameter int TIMEOUT_CYC = TIMEOUT_CYC_DEF
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               start,
    input  logic               abort,
    input  logic [MD_W-1:0]    m_start,
    input  logic [MD_W-1:0]    m_end,
    input  logic [MD_W-1:0]    m_step,
    input  logic [MD_W-1:0]    d_val,
    input  logic [DWELL_W-1:0] dwell,
    input  logic               busy,
    input  logic               lckd,
    output logic [MD_W-1:0]    multiplier,
    output logic [MD_W-1:0]    divider,
    output logic               go,
    output logic               active,
    output logic               done,
    output logic               err,
    output logic [MD_W-1:0]    cur_m,
    output sweep_state_t       dbg_state
);

    localparam int TO_W = $clog2(TIMEOUT_CYC + 1);

    sweep_state_t       r_state;
    logic [MD_W-1:0]    r_m_start, r_m_end, r_m_step, r_d_val, r_cur_m;
    logic [MD_W-1:0]    r_multiplier, r_divider;
    logic [DWELL_W-1:0] r_dwell;
    logic               r_go, r_done, r_err, r_seen_busy, r_lckd;

    logic               w_to_load, w_to_en, w_to_tc;
    logic               w_dw_load, w_dw_en, w_dw_tc;
    logic [DWELL_W-1:0] w_dw_val;
    logic [MD_W:0]      w_sum, w_diff;
    logic [MD_W-1:0]    w_next_m;
    logic               w_dir_up, w_last;

    // Timeout spans both wait states, counted from the go cycle.
    assign w_to_load = (r_state == S_PROG);
    assign w_to_en   = (r_state == S_WAIT_BUSY) || (r_state == S_WAIT_LOCK);
    assign w_dw_load = (r_state == S_WAIT_LOCK) && r_lckd;
    assign w_dw_en   = (r_state == S_DWELL);
    assign w_dw_val  = (r_dwell == '0) ? DWELL_W'(1) : r_dwell;

    sweep_timer #(.W(TO_W)) u_timeout (
        .clk        (clk),
        .reset_n    (reset_n),
        .i_load     (w_to_load),
        .i_load_val (TO_W'(TIMEOUT_CYC)),
        .i_en       (w_to_en),
        .o_tc       (w_to_tc)
    );

    sweep_timer #(.W(DWELL_W)) u_dwell (
        .clk        (clk),
        .reset_n    (reset_n),
        .i_load     (w_dw_load),
        .i_load_val (w_dw_val),
        .i_en       (w_dw_en),
        .o_tc       (w_dw_tc)
    );

    // Next M: one extra bit catches wrap; any result at or past m_end clamps.
    always_comb begin
        w_dir_up = (r_m_end > r_m_start);
        w_sum    = {1'b0, r_cur_m} + {1'b0, r_m_step};
        w_diff   = {1'b0, r_cur_m} - {1'b0, r_m_step};
        w_next_m = r_m_end;
        if (w_dir_up) begin
            if (!w_sum[MD_W] && (w_sum[MD_W-1:0] < r_m_end))
                w_next_m = w_sum[MD_W-1:0];
        end else begin
            if (!w_diff[MD_W] && (w_diff[MD_W-1:0] > r_m_end))
                w_next_m = w_diff[MD_W-1:0];
        end
        w_last = (r_cur_m == r_m_end) || (r_m_step == '0);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state      <= S_IDLE;
            r_m_start    <= '0;
            r_m_end      <= '0;
            r_m_step     <= '0;
            r_d_val      <= '0;
            r_dwell      <= '0;
            r_cur_m      <= '0;
            r_multiplier <= '0;
            r_divider    <= '0;
            r_go         <= 1'b0;
            r_done       <= 1'b0;
            r_err        <= 1'b0;
            r_seen_busy  <= 1'b0;
            r_lckd       <= 1'b0;
        end else begin
            r_go   <= 1'b0;
            r_done <= 1'b0;
            r_lckd <= lckd;
            if (abort) begin
                r_state <= S_IDLE;
            end else begin
                case (r_state)
                    S_IDLE, S_DONE, S_ERR: begin
                        if (start) begin
                            r_m_start <= m_start;
                            r_m_end   <= m_end;
                            r_m_step  <= m_step;
                            r_d_val   <= d_val;
                            r_dwell   <= dwell;
                            r_cur_m   <= m_start;
                            r_err     <= 1'b0;
                            r_state   <= S_PROG;
                        end
                    end
                    S_PROG: begin
                        r_multiplier <= r_cur_m;
                        r_divider    <= r_d_val;
                        r_go         <= 1'b1;
                        r_seen_busy  <= 1'b0;
                        r_state      <= S_WAIT_BUSY;
                    end
                    S_WAIT_BUSY: begin
                        if (w_to_tc) begin
                            r_err   <= 1'b1;
                            r_state <= S_ERR;
                        end else begin
                            if (busy) r_seen_busy <= 1'b1;
                            // Lock is only looked at after a full BUSY cycle,
                            // so a stale LOCKED from the previous point is ignored.
                            if (r_seen_busy && !busy) r_state <= S_WAIT_LOCK;
                        end
                    end
                    S_WAIT_LOCK: begin
                        if (w_to_tc) begin
                            r_err   <= 1'b1;
                            r_state <= S_ERR;
                        end else if (r_lckd) begin
                            r_state <= S_DWELL;
                        end
                    end
                    S_DWELL: begin
                        if (w_dw_tc) r_state <= S_STEP;
                    end
                    S_STEP: begin
                        if (w_last) begin
                            r_done <= 1'b1;
`ifdef FREQ_SWEEP_LOOP_EN
                            r_cur_m <= r_m_start;
                            r_state <= S_PROG;
`else
                            r_state <= S_DONE;
`endif
                        end else begin
                            r_cur_m <= w_next_m;
                            r_state <= S_PROG;
                        end
                    end
                    default: r_state <= S_IDLE;
                endcase
            end
        end
    end

    assign multiplier = r_multiplier;
    assign divider    = r_divider;
    assign go         = r_go;
    assign done       = r_done;
    assign err        = r_err;
    assign cur_m      = r_cur_m;
    assign active     = state_is_active(r_state);
    assign dbg_state  = r_state;

endmodule

// File: tb/tb_freq_sweep_ctrl.sv
// Directed bench for freq_sweep_ctrl with a simple dcmspi/DCM model:
// BUSY for 4 cycles after GO, LOCKED 20 cycles after BUSY falls.
module tb_freq_sweep_ctrl;
  import freqgen_pkg::*;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        start = 1'b0;
  logic        abort = 1'b0;
  logic [7:0]  m_start = '0, m_end = '0, m_step = '0, d_val = '0;
  logic [31:0] dwell = '0;
  logic        busy, lckd;
  logic [7:0]  multiplier, divider, cur_m;
  logic        go, active, done, err;
  sweep_state_t dbg_state;

  int total = 0;
  int bad = 0;
  logic [7:0] exp_q[$];
  logic [7:0] got_m_q[$];
  logic [7:0] got_d_q[$];
  int done_cnt = 0;
  bit lock_en = 1'b1;
  bit keep_lock = 1'b0;
  int b_cnt, l_cnt;

  freq_sweep_ctrl #(.MD_W(8), .DWELL_W(32), .TIMEOUT_CYC(100)) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .abort(abort),
    .m_start(m_start), .m_end(m_end), .m_step(m_step), .d_val(d_val),
    .dwell(dwell), .busy(busy), .lckd(lckd),
    .multiplier(multiplier), .divider(divider), .go(go), .active(active),
    .done(done), .err(err), .cur_m(cur_m), .dbg_state(dbg_state)
  );

  // clock / watchdog
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  // dcmspi + DCM model
  initial begin
    busy = 1'b0; lckd = 1'b1; b_cnt = 0; l_cnt = 0;
    forever begin
      @(negedge clk);
      if (go === 1'b1) begin
        busy = 1'b1;
        if (!keep_lock) lckd = 1'b0;
        b_cnt = 4; l_cnt = 0;
      end else if (b_cnt > 0) begin
        b_cnt--;
        if (b_cnt == 0) begin busy = 1'b0; l_cnt = 20; end
      end else if (l_cnt > 0) begin
        l_cnt--;
        if (l_cnt == 0 && lock_en) lckd = 1'b1;
      end
    end
  end

  // monitor: records every go and counts done pulses
  initial begin
    forever begin
      @(negedge clk);
      if (go === 1'b1) begin
        got_m_q.push_back(multiplier);
        got_d_q.push_back(divider);
      end
      if (done === 1'b1) done_cnt++;
    end
  end

  // driver tasks
  task automatic clear_sb();
    exp_q.delete(); got_m_q.delete(); got_d_q.delete(); done_cnt = 0;
  endtask

  task automatic start_sweep(input logic [7:0] ms, input logic [7:0] me, input logic [7:0] st,
                             input logic [7:0] dv, input logic [31:0] dw);
    @(negedge clk);
    m_start = ms; m_end = me; m_step = st; d_val = dv; dwell = dw;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_state(input sweep_state_t s, input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      if (dbg_state === s) begin ok = 1'b1; break; end
      @(negedge clk);
    end
  endtask

  task automatic wait_done(input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      if (done === 1'b1) begin ok = 1'b1; break; end
      @(negedge clk);
    end
  endtask

  task automatic wait_gos(input int n, input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (got_m_q.size() >= n) begin ok = 1'b1; break; end
    end
  endtask

  // tests
  task automatic test_reset();
    reset_n = 1'b0;
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    total++; if (multiplier !== 8'd0) begin bad++; $display("FAIL rst_mult: got=%0d exp=0", multiplier); end
    total++; if (divider !== 8'd0) begin bad++; $display("FAIL rst_div: got=%0d exp=0", divider); end
    total++; if (go !== 1'b0) begin bad++; $display("FAIL rst_go: got=%b exp=0", go); end
    total++; if (active !== 1'b0) begin bad++; $display("FAIL rst_active: got=%b exp=0", active); end
    total++; if (done !== 1'b0) begin bad++; $display("FAIL rst_done: got=%b exp=0", done); end
    total++; if (err !== 1'b0) begin bad++; $display("FAIL rst_err: got=%b exp=0", err); end
    total++; if (cur_m !== 8'd0) begin bad++; $display("FAIL rst_cur_m: got=%0d exp=0", cur_m); end
    total++; if (dbg_state !== S_IDLE) begin bad++; $display("FAIL rst_state: got=%0d exp=%0d", dbg_state, S_IDLE); end
  endtask

  task automatic test_up_sweep();
    bit ok;
    int n;
    clear_sb();
    exp_q = '{8'd10, 8'd13, 8'd16};
    start_sweep(8'd10, 8'd16, 8'd3, 8'd5, 32'd5);
    total++; if (dbg_state !== S_PROG || go !== 1'b0) begin bad++; $display("FAIL up_prog: got state=%0d go=%b exp state=%0d go=0", dbg_state, go, S_PROG); end
    @(negedge clk);
    total++; if (go !== 1'b1 || multiplier !== 8'd10 || divider !== 8'd5) begin bad++; $display("FAIL up_first_go: got go=%b m=%0d d=%0d exp go=1 m=10 d=5", go, multiplier, divider); end
    total++; if (active !== 1'b1) begin bad++; $display("FAIL up_active: got=%b exp=1", active); end
    wait_state(S_DWELL, 200, ok);
    total++; if (!ok) begin bad++; $display("FAIL up_reach_dwell: got=timeout exp=DWELL"); end
    total++; if (cur_m !== 8'd10) begin bad++; $display("FAIL up_cur_m: got=%0d exp=10", cur_m); end
    n = 0;
    while (dbg_state === S_DWELL && n < 100) begin n++; @(negedge clk); end
    total++; if (n != 5) begin bad++; $display("FAIL up_dwell_len: got=%0d exp=5", n); end
    wait_done(500, ok);
    total++; if (!ok) begin bad++; $display("FAIL up_done_seen: got=timeout exp=done"); end
    total++; if (active !== 1'b0 || dbg_state !== S_DONE || err !== 1'b0) begin bad++; $display("FAIL up_done_state: got active=%b state=%0d err=%b exp 0/%0d/0", active, dbg_state, err, S_DONE); end
    @(negedge clk);
    total++; if (done !== 1'b0) begin bad++; $display("FAIL up_done_pulse: got=%b exp=0", done); end
    total++; if (got_m_q.size() != 3) begin bad++; $display("FAIL up_go_count: got=%0d exp=3", got_m_q.size()); end
    for (int i = 0; i < 3 && i < got_m_q.size(); i++) begin
      total++; if (got_m_q[i] !== exp_q[i] || got_d_q[i] !== 8'd5) begin bad++; $display("FAIL up_go_val%0d: got m=%0d d=%0d exp m=%0d d=5", i, got_m_q[i], got_d_q[i], exp_q[i]); end
    end
    total++; if (done_cnt != 1) begin bad++; $display("FAIL up_done_cnt: got=%0d exp=1", done_cnt); end
  endtask

  task automatic test_down_sweep();
    bit ok;
    clear_sb();
    exp_q = '{8'd20, 8'd15, 8'd12};
    start_sweep(8'd20, 8'd12, 8'd5, 8'd9, 32'd2);
    wait_done(600, ok);
    total++; if (!ok) begin bad++; $display("FAIL dn_done_seen: got=timeout exp=done"); end
    repeat (3) @(negedge clk);
    total++; if (got_m_q.size() != 3) begin bad++; $display("FAIL dn_go_count: got=%0d exp=3", got_m_q.size()); end
    for (int i = 0; i < 3 && i < got_m_q.size(); i++) begin
      total++; if (got_m_q[i] !== exp_q[i] || got_d_q[i] !== 8'd9) begin bad++; $display("FAIL dn_go_val%0d: got m=%0d d=%0d exp m=%0d d=9", i, got_m_q[i], got_d_q[i], exp_q[i]); end
    end
    total++; if (done_cnt != 1) begin bad++; $display("FAIL dn_done_cnt: got=%0d exp=1", done_cnt); end
  endtask

  task automatic test_single_point();
    bit ok;
    int n;
    clear_sb();
    start_sweep(8'd7, 8'd9, 8'd0, 8'd3, 32'd0);
    wait_state(S_DWELL, 200, ok);
    total++; if (!ok) begin bad++; $display("FAIL one_reach_dwell: got=timeout exp=DWELL"); end
    n = 0;
    while (dbg_state === S_DWELL && n < 100) begin n++; @(negedge clk); end
    total++; if (n != 1) begin bad++; $display("FAIL one_dwell_zero: got=%0d exp=1", n); end
    wait_done(50, ok);
    total++; if (!ok) begin bad++; $display("FAIL one_done_seen: got=timeout exp=done"); end
    @(negedge clk);
    total++; if (got_m_q.size() != 1) begin bad++; $display("FAIL one_go_count: got=%0d exp=1", got_m_q.size()); end
    if (got_m_q.size() > 0) begin
      total++; if (got_m_q[0] !== 8'd7 || got_d_q[0] !== 8'd3) begin bad++; $display("FAIL one_go_val: got m=%0d d=%0d exp m=7 d=3", got_m_q[0], got_d_q[0]); end
    end
  endtask

  task automatic test_stale_lock();
    bit ok;
    keep_lock = 1'b1;
    clear_sb();
    start_sweep(8'd30, 8'd30, 8'd0, 8'd1, 32'd1);
    @(negedge clk);
    total++; if (go !== 1'b1) begin bad++; $display("FAIL stale_go: got=%b exp=1", go); end
    for (int k = 1; k <= 3; k++) begin
      @(negedge clk);
      total++; if (dbg_state !== S_WAIT_BUSY) begin bad++; $display("FAIL stale_gate%0d: got state=%0d exp=%0d", k, dbg_state, S_WAIT_BUSY); end
    end
    wait_done(100, ok);
    total++; if (!ok) begin bad++; $display("FAIL stale_done: got=timeout exp=done"); end
    keep_lock = 1'b0;
  endtask

  task automatic test_timeout();
    bit ok;
    lock_en = 1'b0;
    clear_sb();
    start_sweep(8'd4, 8'd4, 8'd0, 8'd1, 32'd1);
    @(negedge clk);
    total++; if (go !== 1'b1) begin bad++; $display("FAIL to_go: got=%b exp=1", go); end
    for (int k = 1; k <= 100; k++) begin
      @(negedge clk);
      if (k == 99) begin
        total++; if (err !== 1'b0 || dbg_state === S_ERR) begin bad++; $display("FAIL to_early: got err=%b state=%0d exp err=0", err, dbg_state); end
      end
      if (k == 100) begin
        total++; if (err !== 1'b1) begin bad++; $display("FAIL to_err: got=%b exp=1", err); end
        total++; if (dbg_state !== S_ERR || active !== 1'b0) begin bad++; $display("FAIL to_state: got state=%0d active=%b exp state=%0d active=0", dbg_state, active, S_ERR); end
      end
    end
    lock_en = 1'b1;
    start_sweep(8'd5, 8'd5, 8'd0, 8'd1, 32'd1);
    total++; if (err !== 1'b0 || dbg_state !== S_PROG) begin bad++; $display("FAIL to_clear: got err=%b state=%0d exp err=0 state=%0d", err, dbg_state, S_PROG); end
    wait_done(200, ok);
    total++; if (!ok || err !== 1'b0) begin bad++; $display("FAIL to_recover: got done_ok=%b err=%b exp 1/0", ok, err); end
  endtask

  task automatic test_abort();
    bit ok;
    clear_sb();
    start_sweep(8'd10, 8'd16, 8'd3, 8'd2, 32'd50);
    wait_gos(2, 400, ok);
    total++; if (!ok) begin bad++; $display("FAIL ab_second_go: got=timeout exp=2 gos"); end
    wait_state(S_DWELL, 200, ok);
    total++; if (!ok || multiplier !== 8'd13) begin bad++; $display("FAIL ab_dwell2: got ok=%b m=%0d exp 1/13", ok, multiplier); end
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    total++; if (dbg_state !== S_IDLE || active !== 1'b0 || go !== 1'b0) begin bad++; $display("FAIL ab_idle: got state=%0d active=%b go=%b exp %0d/0/0", dbg_state, active, go, S_IDLE); end
    total++; if (multiplier !== 8'd13 || divider !== 8'd2) begin bad++; $display("FAIL ab_keep_md: got m=%0d d=%0d exp 13/2", multiplier, divider); end
    // abort and start together: abort takes precedence
    m_start = 8'd40; m_end = 8'd40; m_step = 8'd0;
    abort = 1'b1; start = 1'b1;
    @(negedge clk);
    abort = 1'b0; start = 1'b0;
    total++; if (dbg_state !== S_IDLE) begin bad++; $display("FAIL ab_vs_start: got state=%0d exp=%0d", dbg_state, S_IDLE); end
    repeat (80) @(negedge clk);
    total++; if (got_m_q.size() != 2 || done_cnt != 0) begin bad++; $display("FAIL ab_quiet: got gos=%0d dones=%0d exp 2/0", got_m_q.size(), done_cnt); end
  endtask

  task automatic test_async_reset();
    bit ok;
    start_sweep(8'd10, 8'd16, 8'd3, 8'd2, 32'd5);
    wait_state(S_WAIT_BUSY, 50, ok);
    total++; if (!ok || multiplier !== 8'd10) begin bad++; $display("FAIL ar_setup: got ok=%b m=%0d exp 1/10", ok, multiplier); end
    #2 reset_n = 1'b0;
    #1;
    total++; if (multiplier !== 8'd0 || divider !== 8'd0 || cur_m !== 8'd0) begin bad++; $display("FAIL ar_md: got m=%0d d=%0d cur=%0d exp 0/0/0", multiplier, divider, cur_m); end
    total++; if (go !== 1'b0 || active !== 1'b0 || done !== 1'b0 || err !== 1'b0 || dbg_state !== S_IDLE) begin bad++; $display("FAIL ar_ctrl: got go=%b act=%b done=%b err=%b state=%0d exp 0/0/0/0/0", go, active, done, err, dbg_state); end
    @(negedge clk);
    reset_n = 1'b1;
    repeat (40) @(negedge clk);
  endtask

`ifdef FREQ_SWEEP_LOOP_EN
  task automatic test_loop();
    bit ok;
    clear_sb();
    exp_q = '{8'd10, 8'd12, 8'd10, 8'd12};
    start_sweep(8'd10, 8'd12, 8'd2, 8'd1, 32'd3);
    wait_gos(4, 800, ok);
    total++; if (!ok) begin bad++; $display("FAIL loop_gos: got=timeout exp=4 gos"); end
    for (int i = 0; i < 4 && i < got_m_q.size(); i++) begin
      total++; if (got_m_q[i] !== exp_q[i]) begin bad++; $display("FAIL loop_val%0d: got=%0d exp=%0d", i, got_m_q[i], exp_q[i]); end
    end
    total++; if (done_cnt != 1 || active !== 1'b1) begin bad++; $display("FAIL loop_pass: got dones=%0d active=%b exp 1/1", done_cnt, active); end
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    total++; if (dbg_state !== S_IDLE) begin bad++; $display("FAIL loop_abort: got=%0d exp=%0d", dbg_state, S_IDLE); end
  endtask
`endif

  initial begin
    test_reset();
`ifdef FREQ_SWEEP_LOOP_EN
    test_loop();
    test_timeout_loopless_skip: begin end
`else
    test_up_sweep();
    test_down_sweep();
    test_single_point();
    test_stale_lock();
    test_timeout();
    test_abort();
`endif
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/freq_sweep_ctrl.md
# freq_sweep_ctrl

Sequencer that drives the DCM_CLKGEN SPI programmer (dcmspi) through a stepped sweep of multiplier values at a fixed divider, dwelling a programmable number of cycles at each point. It sits between serial_decode, which supplies sweep parameters and a start strobe, and dcmspi, whose M/D/GO inputs it owns while a sweep is active. Each step waits for dcmspi BUSY to complete and the DCM to re-lock, with a timeout that aborts the sweep on failure.

## Interface
Parameters:
- MD_W, 8, width of M/D values (dcmspi encoding, passed through unmodified)
- DWELL_W, 32, width of dwell counter
- TIMEOUT_CYC, 1000000, max cycles from GO to lock before error

Ports:
- clk  in  1  system clock (clk50m)
- reset_n  in  1  asynchronous, active-low reset
- start  in  1  one-cycle pulse; latches parameters and begins sweep
- abort  in  1  level; forces IDLE
- m_start  in  MD_W  first M value
- m_end  in  MD_W  last M value
- m_step  in  MD_W  step magnitude; 0 = single point
- d_val  in  MD_W  D value for all points
- dwell  in  DWELL_W  cycles to hold each point after lock; 0 treated as 1
- busy  in  1  dcmspi BUSY
- lckd  in  1  DCM LOCKED
- multiplier  out  MD_W  M to dcmspi
- divider  out  MD_W  D to dcmspi
- go  out  1  one-cycle GO pulse to dcmspi
- active  out  1  high outside IDLE/DONE/ERR
- done  out  1  one-cycle pulse on sweep completion
- err  out  1  sticky timeout flag; cleared by next accepted start
- cur_m  out  MD_W  M currently programmed or being programmed

## Operation
- States: IDLE, PROG, WAIT_BUSY, WAIT_LOCK, DWELL, STEP, DONE, ERR.
- IDLE/DONE/ERR: start latches m_start, m_end, m_step, d_val, dwell; cur_m <= m_start; err <= 0; -> PROG. start in any other state ignored.
- PROG: multiplier <= cur_m, divider <= d_val, go = 1 for exactly one cycle; timeout counter loaded; -> WAIT_BUSY.
- WAIT_BUSY: sets seen_busy on busy=1; -> WAIT_LOCK when seen_busy and busy=0.
- WAIT_LOCK: -> DWELL when lckd=1; dwell counter loaded.
- Timeout counter runs through WAIT_BUSY and WAIT_LOCK; at TIMEOUT_CYC cycles after go: err <= 1, -> ERR.
- DWELL: counts down; -> STEP when count reaches 1.
- STEP: if cur_m == m_end or m_step == 0 -> DONE (done pulse). Else direction = up if m_end > m_start, down otherwise; next = cur_m ± m_step computed MD_W+1 bits; if next passes m_end or over/underflows MD_W, next = m_end. cur_m <= next; -> PROG.
- abort=1 in any state: -> IDLE next cycle, go held 0, no done. multiplier/divider keep last values; an in-flight dcmspi transfer completes independently.
- abort and start same cycle: abort wins.

## Timing
- Reset values: multiplier 0, divider 0, go 0, active 0, done 0, err 0, cur_m 0; state IDLE.
- start -> go: 2 cycles (start cycle latches, PROG cycle issues go registered).
- multiplier/divider stable from go cycle until next PROG.
- lckd sampled registered; WAIT_LOCK -> DWELL 1 cycle after lckd high.
- STEP -> PROG -> go: 2 cycles between dwell end and next go.
- done asserted the cycle after STEP; active falls the same cycle.
- Stale lckd=1 before dcmspi asserts busy is never accepted (seen_busy gate).

## Configuration
- FREQ_SWEEP_LOOP_EN defined: at STEP with cur_m == m_end, cur_m <= latched m_start and -> PROG; sweep repeats until abort; done pulses once per completed pass, active stays high.
- Undefined: sweep stops in DONE after one pass.

## Structure
- Shared package freqgen_pkg: state encoding constants, MD_W default, TIMEOUT_CYC default.
- One sub-module: sweep_timer (loadable down-counter, terminal-count output), instantiated twice for dwell and timeout.

## Test plan
- m_start=10, m_end=16, m_step=3, dwell=5, dcmspi model busy 4 cycles, lock 20 cycles later -> go issued with M=10,13,16, then done; no err.
- m_start=20, m_end=12, m_step=5 -> M=20,15,12 (clamped), done pulse once.
- m_step=0, m_start=7 -> single go with M=7, D=d_val, then done.
- lckd held 0, TIMEOUT_CYC=100 -> err=1 exactly 100 cycles after go, state ERR, active=0; next start clears err.
- abort asserted in DWELL of second point -> IDLE next cycle, no further go, no done; reset_n low mid-sweep -> all outputs to reset values asynchronously.
- FREQ_SWEEP_LOOP_EN: 10->12 step 2 -> go sequence 10,12,10,12... with done per pass until abort.
